// File: rtl/legv8_pkg.sv
// Shared encodings for the LEGv8 multi-cycle controller: opcodes, control codes,
// FSM states, instruction classes and trap causes.
package legv8_pkg;

    localparam int unsigned OPC_W   = 11;
    localparam int unsigned IMM_W   = 3;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned CAUSE_W = 2;

    localparam logic [OPC_W-1:0] OP_ADD   = 11'h458;
    localparam logic [OPC_W-1:0] OP_SUB   = 11'h658;
    localparam logic [OPC_W-1:0] OP_AND   = 11'h450;
    localparam logic [OPC_W-1:0] OP_ORR   = 11'h550;
    localparam logic [OPC_W-1:0] OP_ADDI0 = 11'h488;
    localparam logic [OPC_W-1:0] OP_ADDI1 = 11'h489;
    localparam logic [OPC_W-1:0] OP_SUBI0 = 11'h688;
    localparam logic [OPC_W-1:0] OP_SUBI1 = 11'h689;
    localparam logic [OPC_W-1:0] OP_LDUR  = 11'h7C2;
    localparam logic [OPC_W-1:0] OP_STUR  = 11'h7C0;

    // Prefix matches on the upper opcode bits for the variable-length opcodes
    localparam logic [5:0] OP_B_PFX    = 6'b000101;
    localparam logic [7:0] OP_CBZ_PFX  = 8'b10110100;
    localparam logic [8:0] OP_MOVZ_PFX = 9'b110100101;

    typedef enum logic [IMM_W-1:0] {
        IMM_I    = 3'b000,
        IMM_D    = 3'b001,
        IMM_B    = 3'b010,
        IMM_CB   = 3'b011,
        IMM_MOVZ = 3'b100
    } imm_sel_e;

    typedef enum logic [ALU_W-1:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LDUR,
        CLS_STUR,
        CLS_B,
        CLS_CBZ,
        CLS_MOVZ
    } cls_e;

    typedef enum logic [CAUSE_W-1:0] {
        TC_NONE    = 2'b00,
        TC_ILLEGAL = 2'b01,
        TC_IMEM    = 2'b10,
        TC_DMEM    = 2'b11
    } trap_cause_e;

    typedef struct packed {
        cls_e     cls;
        imm_sel_e imm_ctrl;
        alu_op_e  alu_op;
        logic     alu_src_b;
        logic     reg2loc;
        logic     illegal;
    } dec_t;

    typedef struct packed {
        cls_e     cls;
        imm_sel_e imm_ctrl;
        alu_op_e  alu_op;
        logic     alu_src_b;
        logic     reg2loc;
        logic     mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: decoded opcode and handshakes in,
// control strobes and trap status out.
interface legv8_multicycle_ctrl_if;

    logic [legv8_pkg::OPC_W-1:0]   opcode;
    logic                          zero;
    logic                          imem_ack;
    logic                          dmem_ack;
    logic                          imem_req;
    logic                          dmem_req;
    logic                          dmem_we;
    logic                          ir_we;
    logic                          pc_we;
    logic                          pc_src;
    logic [legv8_pkg::IMM_W-1:0]   imm_ctrl;
    logic                          alu_src_b;
    logic [legv8_pkg::ALU_W-1:0]   alu_op;
    logic                          reg2loc;
    logic                          reg_we;
    logic                          mem_to_reg;
    logic                          retired;
    logic                          trap;
    logic [legv8_pkg::CAUSE_W-1:0] trap_cause;

    modport master (
        input  opcode, zero, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, imm_ctrl,
               alu_src_b, alu_op, reg2loc, reg_we, mem_to_reg, retired,
               trap, trap_cause
    );

    modport slave (
        output opcode, zero, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, imm_ctrl,
               alu_src_b, alu_op, reg2loc, reg_we, mem_to_reg, retired,
               trap, trap_cause
    );

endinterface

// File: rtl/legv8_decode.sv
// Combinational opcode classifier producing the per-instruction control fields.
module legv8_decode
    import legv8_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output dec_t             dec
);

    always_comb begin
        dec.cls       = CLS_R;
        dec.imm_ctrl  = IMM_I;
        dec.alu_op    = ALU_ADD;
        dec.alu_src_b = 1'b0;
        dec.reg2loc   = 1'b0;
        dec.illegal   = 1'b0;
        case (opcode)
            OP_ADD: dec.alu_op = ALU_ADD;
            OP_SUB: dec.alu_op = ALU_SUB;
            OP_AND: dec.alu_op = ALU_AND;
            OP_ORR: dec.alu_op = ALU_ORR;
            OP_ADDI0, OP_ADDI1: begin
                dec.cls       = CLS_I;
                dec.alu_src_b = 1'b1;
            end
            OP_SUBI0, OP_SUBI1: begin
                dec.cls       = CLS_I;
                dec.alu_op    = ALU_SUB;
                dec.alu_src_b = 1'b1;
            end
            OP_LDUR: begin
                dec.cls       = CLS_LDUR;
                dec.imm_ctrl  = IMM_D;
                dec.alu_src_b = 1'b1;
            end
            OP_STUR: begin
                // Store data comes from Rt, so the second read port is steered there
                dec.cls       = CLS_STUR;
                dec.imm_ctrl  = IMM_D;
                dec.alu_src_b = 1'b1;
                dec.reg2loc   = 1'b1;
            end
            default: begin
                if (opcode[10:5] == OP_B_PFX) begin
                    dec.cls      = CLS_B;
                    dec.imm_ctrl = IMM_B;
                end else if (opcode[10:3] == OP_CBZ_PFX) begin
                    dec.cls      = CLS_CBZ;
                    dec.imm_ctrl = IMM_CB;
                    dec.alu_op   = ALU_PASSB;
                    dec.reg2loc  = 1'b1;
                end else if (opcode[10:2] == OP_MOVZ_PFX) begin
                    dec.cls       = CLS_MOVZ;
                    dec.imm_ctrl  = IMM_MOVZ;
                    dec.alu_op    = ALU_PASSB;
                    dec.alu_src_b = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: sequences fetch/decode/exec/mem/wb over the
// shared memory handshake and traps on illegal opcodes or ack timeouts.
module legv8_multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    CLK,
    input  logic                    resetl,
    legv8_multicycle_ctrl_if.master bus
);

    localparam int unsigned CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    trap_cause_e        cause_q, cause_d;
    ctrl_t              ctrl_q, ctrl_d;
    dec_t               dec;

    legv8_decode u_decode (
        .opcode (bus.opcode),
        .dec    (dec)
    );

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            cause_q <= TC_NONE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next-state, wait counter, trap cause and decode-register capture
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cause_d = cause_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                wait_d  = '0;
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    state_d = ST_DECODE;
                end else if (wait_q == WAIT_LIM) begin
                    state_d = ST_TRAP;
                    cause_d = TC_IMEM;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (dec.illegal) begin
                    state_d = ST_TRAP;
                    cause_d = TC_ILLEGAL;
                end else begin
                    state_d           = ST_EXEC;
                    ctrl_d.cls        = dec.cls;
                    ctrl_d.imm_ctrl   = dec.imm_ctrl;
                    ctrl_d.alu_op     = dec.alu_op;
                    ctrl_d.alu_src_b  = dec.alu_src_b;
                    ctrl_d.reg2loc    = dec.reg2loc;
                    ctrl_d.mem_to_reg = (dec.cls == CLS_LDUR);
                end
            end
            ST_EXEC: begin
                wait_d = '0;
                case (ctrl_q.cls)
                    CLS_LDUR, CLS_STUR: state_d = ST_MEM;
                    CLS_B, CLS_CBZ:     state_d = ST_FETCH;
                    default:            state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (bus.dmem_ack) begin
                    state_d = (ctrl_q.cls == CLS_STUR) ? ST_FETCH : ST_WB;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LIM) begin
                    state_d = ST_TRAP;
                    cause_d = TC_DMEM;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                wait_d  = '0;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes follow the registered state (and ack in FETCH/MEM) so reset kills them at once
    logic in_fetch, in_exec, in_mem, in_wb;
    logic is_stur, is_b, is_cbz;
    logic mem_done;

    assign in_fetch = (state_q == ST_FETCH);
    assign in_exec  = (state_q == ST_EXEC);
    assign in_mem   = (state_q == ST_MEM);
    assign in_wb    = (state_q == ST_WB);
    assign is_stur  = (ctrl_q.cls == CLS_STUR);
    assign is_b     = (ctrl_q.cls == CLS_B);
    assign is_cbz   = (ctrl_q.cls == CLS_CBZ);
    assign mem_done = in_mem && bus.dmem_ack && is_stur;

    assign bus.imem_req   = in_fetch;
    assign bus.ir_we      = in_fetch && bus.imem_ack;
    assign bus.dmem_req   = in_mem;
    assign bus.dmem_we    = in_mem && is_stur;
    assign bus.pc_we      = (in_exec && (is_b || is_cbz)) || mem_done || in_wb;
    assign bus.pc_src     = in_exec && (is_b || (is_cbz && bus.zero));
    assign bus.reg_we     = in_wb;
    assign bus.retired    = bus.pc_we;
    assign bus.trap       = (state_q == ST_TRAP);
    assign bus.trap_cause = cause_q;
    assign bus.imm_ctrl   = ctrl_q.imm_ctrl;
    assign bus.alu_op     = ctrl_q.alu_op;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.reg2loc    = ctrl_q.reg2loc;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed self-checking bench for legv8_multicycle_ctrl.
module tb_legv8_multicycle_ctrl;

    localparam logic [8:0] S_IREQ  = 9'h100;
    localparam logic [8:0] S_IRWE  = 9'h080;
    localparam logic [8:0] S_DREQ  = 9'h040;
    localparam logic [8:0] S_DWE   = 9'h020;
    localparam logic [8:0] S_PCWE  = 9'h010;
    localparam logic [8:0] S_PCSRC = 9'h008;
    localparam logic [8:0] S_REGWE = 9'h004;
    localparam logic [8:0] S_RET   = 9'h002;
    localparam logic [8:0] S_TRAP  = 9'h001;
    localparam logic [8:0] S_WB    = S_REGWE | S_PCWE | S_RET;

    logic clk = 1'b0;
    logic resetl;
    int   checks = 0;
    int   errors = 0;

    legv8_multicycle_ctrl_if bus ();

    legv8_multicycle_ctrl #(.TIMEOUT(16)) dut (
        .CLK    (clk),
        .resetl (resetl),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] strobes();
        return {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.pc_we,
                bus.pc_src, bus.reg_we, bus.retired, bus.trap};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input logic [8:0] exp);
        #1;
        chk(tag, 16'(strobes()), 16'(exp));
    endtask

    task automatic fetch(input string tag, input logic [10:0] op);
        bus.opcode   = op;
        bus.imem_ack = 1'b1;
        chk_s(tag, S_IREQ | S_IRWE);
        cyc();
        bus.imem_ack = 1'b0;
        chk_s({tag, "_dec"}, 9'h000);
        cyc();
    endtask

    // From EXEC of an R/I/MOVZ instruction through WB and back to FETCH
    task automatic alu_tail(input string tag, input logic [3:0] alu, input logic srcb,
                            input logic imm_chk, input logic [2:0] imm);
        chk_s({tag, "_exec"}, 9'h000);
        chk({tag, "_aluop"}, 16'(bus.alu_op), 16'(alu));
        chk({tag, "_srcb"}, 16'(bus.alu_src_b), 16'(srcb));
        if (imm_chk) chk({tag, "_imm"}, 16'(bus.imm_ctrl), 16'(imm));
        cyc();
        chk_s({tag, "_wb"}, S_WB);
        chk({tag, "_m2r"}, 16'(bus.mem_to_reg), 16'h0);
        cyc();
        chk_s({tag, "_back"}, S_IREQ);
    endtask

    task automatic do_reset(input string tag);
        resetl = 1'b0;
        chk_s(tag, 9'h000);
        cyc();
        resetl = 1'b1;
        chk_s({tag, "_idle"}, 9'h000);
        cyc();
        chk_s({tag, "_fetch"}, S_IREQ);
    endtask

    initial begin
        resetl       = 1'b0;
        bus.opcode   = '0;
        bus.zero     = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        cyc();
        cyc();
        chk_s("rst_strobes", 9'h000);
        chk("rst_cause", 16'(bus.trap_cause), 16'h0);
        chk("rst_aluop", 16'(bus.alu_op), 16'h0);
        chk("rst_imm", 16'(bus.imm_ctrl), 16'h0);
        resetl = 1'b1;
        chk_s("idle", 9'h000);
        cyc();
        chk_s("fetch_after_reset", S_IREQ);

        fetch("add", 11'h458);
        alu_tail("add", 4'b0010, 1'b0, 1'b0, 3'b000);

        // LDUR with three wait cycles on the data side
        fetch("ldur", 11'h7C2);
        chk_s("ldur_exec", 9'h000);
        chk("ldur_imm", 16'(bus.imm_ctrl), 16'h1);
        chk("ldur_aluop", 16'(bus.alu_op), 16'h2);
        chk("ldur_srcb", 16'(bus.alu_src_b), 16'h1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk_s("ldur_wait", S_DREQ);
            cyc();
        end
        bus.dmem_ack = 1'b1;
        chk_s("ldur_ack", S_DREQ);
        chk("ldur_m2r_mem", 16'(bus.mem_to_reg), 16'h1);
        cyc();
        bus.dmem_ack = 1'b0;
        chk_s("ldur_wb", S_WB);
        chk("ldur_m2r_wb", 16'(bus.mem_to_reg), 16'h1);
        cyc();
        chk_s("ldur_back", S_IREQ);

        fetch("stur", 11'h7C0);
        chk_s("stur_exec", 9'h000);
        cyc();
        bus.dmem_ack = 1'b1;
        chk_s("stur_ack", S_DREQ | S_DWE | S_PCWE | S_RET);
        cyc();
        bus.dmem_ack = 1'b0;
        chk_s("stur_back", S_IREQ);

        fetch("cbz1", 11'h5A0);
        bus.zero = 1'b1;
        chk_s("cbz1_exec", S_PCWE | S_PCSRC | S_RET);
        chk("cbz1_imm", 16'(bus.imm_ctrl), 16'h3);
        chk("cbz1_aluop", 16'(bus.alu_op), 16'h7);
        chk("cbz1_reg2loc", 16'(bus.reg2loc), 16'h1);
        cyc();
        bus.zero = 1'b0;
        chk_s("cbz1_back", S_IREQ);

        fetch("cbz0", 11'h5A3);
        chk_s("cbz0_exec", S_PCWE | S_RET);
        chk("cbz0_imm", 16'(bus.imm_ctrl), 16'h3);
        cyc();
        chk_s("cbz0_back", S_IREQ);

        fetch("b", 11'h0A0);
        chk_s("b_exec", S_PCWE | S_PCSRC | S_RET);
        chk("b_imm", 16'(bus.imm_ctrl), 16'h2);
        cyc();
        chk_s("b_back", S_IREQ);

        fetch("movz", 11'h694);
        alu_tail("movz", 4'b0111, 1'b1, 1'b1, 3'b100);
        fetch("addi", 11'h489);
        alu_tail("addi", 4'b0010, 1'b1, 1'b1, 3'b000);
        fetch("subi", 11'h688);
        alu_tail("subi", 4'b0110, 1'b1, 1'b1, 3'b000);
        fetch("sub", 11'h658);
        alu_tail("sub", 4'b0110, 1'b0, 1'b0, 3'b000);
        fetch("orr", 11'h550);
        alu_tail("orr", 4'b0001, 1'b0, 1'b0, 3'b000);

        // Ack on the last permitted wait cycle must win over the timeout
        for (int i = 0; i < 15; i++) begin
            chk_s("late_wait", S_IREQ);
            cyc();
        end
        fetch("and_late", 11'h450);
        alu_tail("and_late", 4'b0000, 1'b0, 1'b0, 3'b000);

        // Reset mid-MEM drops every output in the same cycle
        fetch("rmem", 11'h7C2);
        cyc();
        chk_s("rmem_mem", S_DREQ);
        resetl = 1'b0;
        chk_s("rmem_rst", 9'h000);
        chk("rmem_aluop", 16'(bus.alu_op), 16'h0);
        chk("rmem_imm", 16'(bus.imm_ctrl), 16'h0);
        cyc();
        resetl = 1'b1;
        chk_s("rmem_idle", 9'h000);
        cyc();
        chk_s("rmem_fetch", S_IREQ);

        fetch("ill", 11'h000);
        chk_s("ill_trap", S_TRAP);
        chk("ill_cause", 16'(bus.trap_cause), 16'h1);
        bus.imem_ack = 1'b1;
        cyc();
        chk_s("ill_hold", S_TRAP);
        bus.imem_ack = 1'b0;
        cyc();
        chk_s("ill_hold2", S_TRAP);
        chk("ill_cause2", 16'(bus.trap_cause), 16'h1);
        do_reset("rst_ill");

        for (int i = 0; i < 16; i++) begin
            chk_s("ito_wait", S_IREQ);
            cyc();
        end
        chk_s("ito_trap", S_TRAP);
        chk("ito_cause", 16'(bus.trap_cause), 16'h2);
        do_reset("rst_ito");

        fetch("dto", 11'h7C2);
        cyc();
        for (int i = 0; i < 16; i++) begin
            chk_s("dto_wait", S_DREQ);
            cyc();
        end
        chk_s("dto_trap", S_TRAP);
        chk("dto_cause", 16'(bus.trap_cause), 16'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/legv8_multicycle_ctrl.md
# legv8_multicycle_ctrl

Multi-cycle control FSM for the LEGv8 datapath. It sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory handshake. It drives the 3-bit immediate-select code to the sign extender, plus the ALU, register-file, PC and memory control strobes. Illegal opcodes and memory-ack timeouts trap the core until reset.

## Interface
- `TIMEOUT`, 16: max cycles a memory request may wait for ack before trapping (≥2).
- `CLK` in 1: clock, rising edge.
- `resetl` in 1: asynchronous, active-low reset.
- `opcode` in 11: IR[31:21], valid from DECODE onward.
- `zero` in 1: ALU zero flag, valid in EXEC.
- `imem_ack` in 1: instruction memory done.
- `dmem_ack` in 1: data memory done.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data write (STUR).
- `ir_we` out 1: latch IR.
- `pc_we` out 1: update PC.
- `pc_src` out 1: 0 = PC+4, 1 = PC+imm64<<2.
- `imm_ctrl` out 3: 000 I, 001 D, 010 B, 011 CB, 100 MOVZ.
- `alu_src_b` out 1: 1 = imm64.
- `alu_op` out 4: 0010 add, 0110 sub, 0000 and, 0001 orr, 0111 pass-B.
- `reg2loc`, `reg_we`, `mem_to_reg` out 1 each.
- `retired` out 1: one-cycle pulse per completed instruction.
- `trap` out 1: sticky error.
- `trap_cause` out 2: 01 illegal, 10 imem timeout, 11 dmem timeout.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset forces IDLE, all outputs 0, counters 0, and clears the decode register. IDLE → FETCH unconditionally.
- FETCH:
  - `imem_req`=1 until `imem_ack`.
  - On ack: `ir_we`=1 in the same cycle, next state DECODE.
- DECODE:
  - Classifies `opcode`: R (ADD 458, SUB 658, AND 450, ORR 550), I (ADDI 488/489, SUBI 688/689), D (LDUR 7C2, STUR 7C0), B (opcode[10:5]=000101), CB (CBZ opcode[10:3]=10110100), MOVZ (opcode[10:2]=110100101).
  - Registers class, `imm_ctrl` and `alu_op`.
  - No match → TRAP, cause 01.
- EXEC:
  - R/I/MOVZ → WB.
  - D → MEM, with `alu_op`=add and `alu_src_b`=1.
  - B: `pc_we`=1, `pc_src`=1, `retired`=1 → FETCH.
  - CBZ: `alu_op`=pass-B, `reg2loc`=1. Sets `pc_we`=1 and `pc_src`=`zero`, `retired`=1 → FETCH.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 for STUR.
  - On ack, STUR: `pc_we`=1, `pc_src`=0, `retired`=1 → FETCH.
  - On ack, LDUR → WB.
- WB:
  - `reg_we`=1, `pc_we`=1, `pc_src`=0, `retired`=1.
  - `mem_to_reg`=1 for LDUR.
  - Next state FETCH.
- Control fields (`imm_ctrl`, `alu_op`, `alu_src_b`, `reg2loc`, `mem_to_reg`) hold their decoded values from EXEC through WB.
- Wait counter:
  - Clears on entering FETCH or MEM and increments each cycle without ack.
  - Reaching `TIMEOUT`-1 without ack → TRAP, cause 10 (FETCH) or 11 (MEM).
  - Ack arriving in the same cycle as the limit wins.
- TRAP: all strobes 0, `trap`=1, cause held; exit only via reset.

## Timing
- Req/ack are level signals. Req stays high until the ack cycle inclusive and drops the next cycle. Ack outside a request is ignored.
- Strobes (`ir_we`, `pc_we`, `reg_we`, `retired`) are Mealy on ack in FETCH/MEM, and Moore in EXEC/WB. Each is high exactly one cycle per instruction.
- Latency with zero-wait ack: R/I/MOVZ 4 cycles, LDUR 5, STUR 4, B/CBZ 3. Each wait cycle adds 1.
- Reset assertion mid-instruction aborts immediately; no strobe fires in that cycle.
- `trap` rises the cycle after the offending DECODE or timeout cycle.

## Structure
- Package `legv8_pkg`: opcode constants/masks, `imm_ctrl` encodings, `alu_op` encodings, state enum, instruction-class enum, trap cause codes.
- Sub-module `legv8_decode`: combinational opcode → {class, imm_ctrl, alu_op, alu_src_b, reg2loc, illegal}. The FSM registers its outputs in DECODE.

## Test plan
- ADD 458, zero-wait acks → `imm_ctrl` irrelevant, `alu_op`=0010, `reg_we` pulse in cycle 4, `retired` once, back to FETCH.
- LDUR 7C2, dmem_ack after 3 waits → `imm_ctrl`=001, `dmem_req` held 4 cycles, `mem_to_reg`=1 and `reg_we` in WB, total 8 cycles.
- CBZ with `zero`=1 then `zero`=0 → `imm_ctrl`=011, `pc_src`=1 then 0, `pc_we` in EXEC, 3 cycles each.
- MOVZ 0x694 → `imm_ctrl`=100, `alu_op`=0111, `alu_src_b`=1, `reg_we` in WB.
- Opcode 0x000 → TRAP, `trap`=1, cause 01, no further `imem_req`. No ack for 16 cycles in FETCH → cause 10.
- `resetl` low during MEM with `dmem_req` high → all outputs 0 immediately. After release: IDLE then `imem_req` on the 2nd cycle.
